// File: rtl/avmm_wr_burst_arbiter_if.sv
// Bus bundle for the two-requester AVMM write arbiter: the requester-facing s_* side,
// the memory-facing m_* side and the response-underflow flag.
interface avmm_wr_burst_arbiter_if #(
  parameter int AVMM_ADDR_WIDTH     = 32,
  parameter int AVMM_DATA_WIDTH     = 512,
  parameter int AVMM_BURSTCNT_WIDTH = 7
);
  localparam int BE_WIDTH = AVMM_DATA_WIDTH / 8;

  logic [1:0]                          s_write;
  logic [1:0][AVMM_ADDR_WIDTH-1:0]     s_address;
  logic [1:0][AVMM_DATA_WIDTH-1:0]     s_writedata;
  logic [1:0][BE_WIDTH-1:0]            s_byteenable;
  logic [1:0][AVMM_BURSTCNT_WIDTH-1:0] s_burstcount;
  logic [1:0]                          s_waitrequest;
  logic [1:0]                          s_writeack;

  logic                                m_write;
  logic [AVMM_ADDR_WIDTH-1:0]          m_address;
  logic [AVMM_DATA_WIDTH-1:0]          m_writedata;
  logic [BE_WIDTH-1:0]                 m_byteenable;
  logic [AVMM_BURSTCNT_WIDTH-1:0]      m_burstcount;
  logic                                m_waitrequest;
  logic                                m_writeresponsevalid;

  logic                                resp_underflow;

  // The arbiter itself.
  modport slave (
    input  s_write, s_address, s_writedata, s_byteenable, s_burstcount,
    input  m_waitrequest, m_writeresponsevalid,
    output s_waitrequest, s_writeack,
    output m_write, m_address, m_writedata, m_byteenable, m_burstcount,
    output resp_underflow
  );

  // The surrounding system: requesters plus the memory channel.
  modport master (
    output s_write, s_address, s_writedata, s_byteenable, s_burstcount,
    output m_waitrequest, m_writeresponsevalid,
    input  s_waitrequest, s_writeack,
    input  m_write, m_address, m_writedata, m_byteenable, m_burstcount,
    input  resp_underflow
  );
endinterface

// File: rtl/avmm_wr_burst_arbiter.sv
// Round-robin whole-burst write arbiter for two AVMM requesters; a tag FIFO remembers
// who owns each issued burst so per-burst write responses become per-word acks.
module avmm_wr_burst_arbiter #(
  parameter int AVMM_ADDR_WIDTH     = 32,
  parameter int AVMM_DATA_WIDTH     = 512,
  parameter int AVMM_BURSTCNT_WIDTH = 7,
  parameter int TAG_FIFO_DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  avmm_wr_burst_arbiter_if.slave  bus
);
  localparam int BCW      = AVMM_BURSTCNT_WIDTH;
  localparam int PTR_W    = $clog2(TAG_FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ACK_W    = BCW + PTR_W;
  localparam int BE_WIDTH = AVMM_DATA_WIDTH / 8;

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic           id;
    logic [BCW-1:0] bc;
  } tag_t;

  state_t                     state, state_nx;
  logic                       owner, owner_nx;
  logic                       last_grant, last_grant_nx;
  logic [BCW-1:0]             beats_left, beats_left_nx;

  logic                       winner;
  logic                       sel;
  logic                       push;
  logic                       pop;
  logic                       fifo_full;
  logic                       blocked;

  tag_t                       tag_mem [TAG_FIFO_DEPTH];
  tag_t                       head;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           tag_count;

  logic [1:0][ACK_W-1:0]      ack_cnt;
  logic [1:0][ACK_W-1:0]      ack_add;
  logic                       underflow_q;

  logic [AVMM_ADDR_WIDTH-1:0] sel_address;
  logic [AVMM_DATA_WIDTH-1:0] sel_writedata;
  logic [BE_WIDTH-1:0]        sel_byteenable;

  // The requester that did not win last time gets priority if it is asking.
  assign winner = bus.s_write[~last_grant] ? ~last_grant : last_grant;
  assign sel    = (state == BURST) ? owner : winner;

  assign sel_address    = bus.s_address[sel];
  assign sel_writedata  = bus.s_writedata[sel];
  assign sel_byteenable = bus.s_byteenable[sel];

  assign bus.m_address    = sel_address;
  assign bus.m_writedata  = sel_writedata;
  assign bus.m_byteenable = sel_byteenable;
  assign bus.m_burstcount = bus.s_burstcount[sel];

  assign fifo_full = (tag_count == CNT_W'(TAG_FIFO_DEPTH));
  assign pop       = bus.m_writeresponsevalid && (tag_count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still admits a new burst then.
  assign blocked   = fifo_full && !bus.m_writeresponsevalid;
  assign head      = tag_mem[rd_ptr];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can infer a latch.
    bus.m_write       = 1'b0;
    bus.s_waitrequest = 2'b11;
    state_nx          = state;
    owner_nx          = owner;
    last_grant_nx     = last_grant;
    beats_left_nx     = beats_left;
    push              = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (!blocked && (|bus.s_write)) begin
            bus.m_write                   = 1'b1;
            bus.s_waitrequest[winner]     = bus.m_waitrequest;
            if (!bus.m_waitrequest) begin
              push = 1'b1;
              if (bus.s_burstcount[winner] <= BCW'(1)) begin
                last_grant_nx = winner;
              end else begin
                state_nx      = BURST;
                owner_nx      = winner;
                beats_left_nx = bus.s_burstcount[winner] - BCW'(1);
              end
            end
          end
        end
        BURST: begin
          bus.m_write              = bus.s_write[owner];
          bus.s_waitrequest[owner] = bus.m_waitrequest;
          if (bus.s_write[owner] && !bus.m_waitrequest) begin
            beats_left_nx = beats_left - BCW'(1);
            if (beats_left == BCW'(1)) begin
              state_nx      = IDLE;
              last_grant_nx = owner;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      beats_left <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
      beats_left <= beats_left_nx;
    end
  end

  // NOTE: the tag storage is not reset; tag_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= '{id: sel, bc: bus.m_burstcount};
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ack_add[i] = (pop && (head.id == 1'(i))) ? ACK_W'(head.bc) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_count   <= '0;
      ack_cnt     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      tag_count <= tag_count + CNT_W'(1);
      else if (!push && pop) tag_count <= tag_count - CNT_W'(1);
      if (bus.m_writeresponsevalid && !pop) underflow_q <= 1'b1;
      // Credit and drain can land together; the counter is wide enough never to wrap.
      for (int i = 0; i < 2; i++) begin
        ack_cnt[i] <= ack_cnt[i] + ack_add[i] - ACK_W'(ack_cnt[i] != '0);
      end
    end
  end

  assign bus.s_writeack[0]  = |ack_cnt[0];
  assign bus.s_writeack[1]  = |ack_cnt[1];
  assign bus.resp_underflow = underflow_q;
endmodule

// File: tb/tb_avmm_wr_burst_arbiter.sv
// Directed bench for avmm_wr_burst_arbiter: a per-cycle vector table plus hand sequences
// for back-pressure on a long burst and overlapping ack credits.
module tb_avmm_wr_burst_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int BCW   = 5;
  localparam int DEPTH = 4;

  localparam logic [AW-1:0]   ADDR0 = 16'h0A00;
  localparam logic [AW-1:0]   ADDR1 = 16'h0B00;
  localparam logic [DW-1:0]   DATA0 = 32'hAAAA_0000;
  localparam logic [DW-1:0]   DATA1 = 32'hBBBB_0000;
  localparam logic [DW/8-1:0] BE0   = 4'hF;
  localparam logic [DW/8-1:0] BE1   = 4'h3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avmm_wr_burst_arbiter_if #(
    .AVMM_ADDR_WIDTH(AW), .AVMM_DATA_WIDTH(DW), .AVMM_BURSTCNT_WIDTH(BCW)
  ) bus ();

  avmm_wr_burst_arbiter #(
    .AVMM_ADDR_WIDTH(AW), .AVMM_DATA_WIDTH(DW), .AVMM_BURSTCNT_WIDTH(BCW),
    .TAG_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic           rst;
    logic [1:0]     wr;
    logic [BCW-1:0] bc0;
    logic [BCW-1:0] bc1;
    logic           mwait;
    logic           rv;
    logic           exp_mw;
    logic           exp_src;
    logic [1:0]     exp_wait;
    logic [1:0]     exp_ack;
    logic           exp_uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [1:0] wr, int bc0, int bc1, logic mwait, logic rv,
                              logic exp_mw, logic exp_src, logic [1:0] exp_wait,
                              logic [1:0] exp_ack, logic exp_uf);
    vec_t v;
    v.rst = rst; v.wr = wr; v.bc0 = BCW'(bc0); v.bc1 = BCW'(bc1);
    v.mwait = mwait; v.rv = rv; v.exp_mw = exp_mw; v.exp_src = exp_src;
    v.exp_wait = exp_wait; v.exp_ack = exp_ack; v.exp_uf = exp_uf;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset                    = 1'b1;
    bus.s_write              = 2'b00;
    bus.m_waitrequest        = 1'b0;
    bus.m_writeresponsevalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(input int r, input int bc);
    for (int b = 0; b < bc; b++) begin
      @(negedge clk);
      bus.s_write         = (r == 1) ? 2'b10 : 2'b01;
      bus.s_burstcount[r] = BCW'(bc);
      bus.m_waitrequest   = 1'b0;
      #1;
      check($sformatf("issue r%0d beat%0d m_write", r, b), bus.m_write, 1'b1);
      check($sformatf("issue r%0d beat%0d m_address", r, b), bus.m_address, (r == 1) ? ADDR1 : ADDR0);
    end
    @(negedge clk);
    bus.s_write = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_b [10];
    int  beat;
    logic done;

    bus.s_address[0]         = ADDR0;
    bus.s_address[1]         = ADDR1;
    bus.s_writedata[0]       = DATA0;
    bus.s_writedata[1]       = DATA1;
    bus.s_byteenable[0]      = BE0;
    bus.s_byteenable[1]      = BE1;
    bus.s_burstcount         = '0;
    bus.s_write              = 2'b00;
    bus.m_waitrequest        = 1'b0;
    bus.m_writeresponsevalid = 1'b0;

    //             rst wr     bc0 bc1 mw rv  mw src wait   ack    uf
    vecs.push_back(mk(1, 2'b11, 4, 2, 0, 0,  0, 0, 2'b11, 2'b00, 0)); // reset outputs
    vecs.push_back(mk(0, 2'b01, 4, 2, 0, 0,  1, 0, 2'b10, 2'b00, 0)); // req0 wins first, burst 4
    vecs.push_back(mk(0, 2'b11, 4, 2, 0, 0,  1, 0, 2'b10, 2'b00, 0));
    vecs.push_back(mk(0, 2'b11, 4, 2, 1, 0,  1, 0, 2'b11, 2'b00, 0)); // stall mid-burst
    vecs.push_back(mk(0, 2'b11, 4, 2, 0, 0,  1, 0, 2'b10, 2'b00, 0));
    vecs.push_back(mk(0, 2'b11, 4, 2, 0, 0,  1, 0, 2'b10, 2'b00, 0)); // 4th beat
    vecs.push_back(mk(0, 2'b11, 2, 2, 0, 0,  1, 1, 2'b01, 2'b00, 0)); // back-to-back grant req1
    vecs.push_back(mk(0, 2'b11, 2, 2, 0, 1,  1, 1, 2'b01, 2'b00, 0)); // response for burst 4
    vecs.push_back(mk(0, 2'b11, 2, 2, 0, 0,  1, 0, 2'b10, 2'b01, 0)); // ack0 x4 starts
    vecs.push_back(mk(0, 2'b11, 2, 2, 0, 0,  1, 0, 2'b10, 2'b01, 0));
    vecs.push_back(mk(0, 2'b11, 2, 2, 0, 0,  1, 1, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, 2'b11, 2, 2, 0, 0,  1, 1, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, 2'b01, 1, 1, 0, 0,  1, 0, 2'b10, 2'b00, 0)); // 4th tag: FIFO full
    vecs.push_back(mk(0, 2'b11, 1, 1, 0, 0,  0, 0, 2'b11, 2'b00, 0)); // full: stalled
    vecs.push_back(mk(0, 2'b11, 1, 1, 0, 1,  1, 1, 2'b01, 2'b00, 0)); // pop frees slot same cycle
    vecs.push_back(mk(0, 2'b00, 1, 1, 0, 1,  0, 0, 2'b11, 2'b10, 0));
    vecs.push_back(mk(0, 2'b00, 1, 1, 0, 1,  0, 0, 2'b11, 2'b11, 0)); // acks overlap
    vecs.push_back(mk(0, 2'b00, 1, 1, 0, 0,  0, 0, 2'b11, 2'b11, 0));
    vecs.push_back(mk(0, 2'b00, 1, 1, 0, 0,  0, 0, 2'b11, 2'b10, 0));
    vecs.push_back(mk(0, 2'b00, 1, 1, 0, 0,  0, 0, 2'b11, 2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 1, 1, 0, 1,  0, 0, 2'b11, 2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 1, 1, 0, 1,  0, 0, 2'b11, 2'b01, 0));
    vecs.push_back(mk(0, 2'b00, 1, 1, 0, 1,  0, 0, 2'b11, 2'b10, 0)); // response with FIFO empty
    vecs.push_back(mk(0, 2'b00, 1, 1, 0, 0,  0, 0, 2'b11, 2'b00, 1)); // sticky underflow
    vecs.push_back(mk(0, 2'b01, 3, 2, 0, 0,  1, 0, 2'b10, 2'b00, 1)); // burst 3 begins
    vecs.push_back(mk(0, 2'b11, 3, 2, 0, 0,  1, 0, 2'b10, 2'b00, 1));
    vecs.push_back(mk(1, 2'b11, 3, 2, 0, 0,  0, 0, 2'b11, 2'b00, 1)); // reset mid-burst
    vecs.push_back(mk(0, 2'b10, 3, 2, 0, 0,  1, 1, 2'b01, 2'b00, 0)); // req1 fresh win
    vecs.push_back(mk(0, 2'b10, 3, 2, 0, 0,  1, 1, 2'b01, 2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 3, 2, 0, 0,  0, 0, 2'b11, 2'b00, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      reset                    = vecs[k].rst;
      bus.s_write              = vecs[k].wr;
      bus.s_burstcount[0]      = vecs[k].bc0;
      bus.s_burstcount[1]      = vecs[k].bc1;
      bus.m_waitrequest        = vecs[k].mwait;
      bus.m_writeresponsevalid = vecs[k].rv;
      #1;
      check($sformatf("v%0d m_write", k), bus.m_write, vecs[k].exp_mw);
      check($sformatf("v%0d s_waitrequest", k), bus.s_waitrequest, vecs[k].exp_wait);
      check($sformatf("v%0d s_writeack", k), bus.s_writeack, vecs[k].exp_ack);
      check($sformatf("v%0d resp_underflow", k), bus.resp_underflow, vecs[k].exp_uf);
      if (vecs[k].exp_mw) begin
        check($sformatf("v%0d m_address", k), bus.m_address, vecs[k].exp_src ? ADDR1 : ADDR0);
        check($sformatf("v%0d m_writedata", k), bus.m_writedata, vecs[k].exp_src ? DATA1 : DATA0);
        check($sformatf("v%0d m_byteenable", k), bus.m_byteenable, vecs[k].exp_src ? BE1 : BE0);
        check($sformatf("v%0d m_burstcount", k), bus.m_burstcount,
              vecs[k].exp_src ? vecs[k].bc1 : vecs[k].bc0);
      end
    end

    // Burst of 8 from req0 with a stall every third cycle; req1 keeps asking throughout.
    do_reset();
    beat = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      bus.m_waitrequest   = (c % 3 == 1);
      bus.s_write         = 2'b11;
      bus.s_burstcount[0] = BCW'(8);
      bus.s_burstcount[1] = BCW'(1);
      bus.s_writedata[0]  = 32'hD000_0000 + DW'(beat);
      #1;
      if (beat < 8) begin
        check($sformatf("bp beat%0d m_write", beat), bus.m_write, 1'b1);
        check($sformatf("bp beat%0d m_writedata", beat), bus.m_writedata, 32'hD000_0000 + DW'(beat));
        check($sformatf("bp beat%0d m_burstcount", beat), bus.m_burstcount, BCW'(8));
        check($sformatf("bp beat%0d loser wait", beat), bus.s_waitrequest[1], 1'b1);
        if (!bus.m_waitrequest) beat++;
      end else begin
        check("bp release to req1", bus.m_address, ADDR1);
        done = 1'b1;
      end
    end
    check("bp completed within budget", done, 1'b1);
    bus.s_writedata[0] = DATA0;

    // Overlapping credits: req0 burst 3, req0 burst 5, req1 burst 2, responses back to back.
    do_reset();
    issue(0, 3);
    issue(0, 5);
    issue(1, 2);
    exp_b = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.m_writeresponsevalid = (c < 3);
      #1;
      check($sformatf("overlap cycle%0d s_writeack", c), bus.s_writeack, exp_b[c]);
    end
    check("overlap no underflow", bus.resp_underflow, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/avmm_wr_burst_arbiter.md
# avmm_wr_burst_arbiter

Two-requester write arbiter for a single local-memory AVMM write port. It grants whole bursts round-robin and records the owner and burst length of every accepted burst in a tag FIFO. It then steers the downstream per-burst write response back to the owning requester as per-word write-acks. It sits between the kernel-system and DMA write masters and the memory-channel write path.

## Interface
- AVMM_ADDR_WIDTH, LOCAL_MEM_ADDR_WIDTH, byte address width.
- AVMM_DATA_WIDTH, 512, write data width; byteenable is AVMM_DATA_WIDTH/8.
- AVMM_BURSTCNT_WIDTH, LOCAL_MEM_BURST_CNT_WIDTH, burstcount width.
- TAG_FIFO_DEPTH, 64, maximum outstanding bursts; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_write  in  [1:0]  per-requester write request.
- s_address  in  [1:0][AVMM_ADDR_WIDTH]  per-requester address.
- s_writedata  in  [1:0][AVMM_DATA_WIDTH]  per-requester data.
- s_byteenable  in  [1:0][AVMM_DATA_WIDTH/8]  per-requester byte enables.
- s_burstcount  in  [1:0][AVMM_BURSTCNT_WIDTH]  per-requester burst length; 0 is illegal.
- s_waitrequest  out  [1:0]  per-requester stall.
- s_writeack  out  [1:0]  per-word write-ack, one cycle per word.
- m_write  out  1  downstream write.
- m_address  out  AVMM_ADDR_WIDTH  downstream address.
- m_writedata  out  AVMM_DATA_WIDTH  downstream data.
- m_byteenable  out  AVMM_DATA_WIDTH/8  downstream byte enables.
- m_burstcount  out  AVMM_BURSTCNT_WIDTH  downstream burst length.
- m_waitrequest  in  1  downstream stall.
- m_writeresponsevalid  in  1  one pulse per completed burst, in issue order.
- resp_underflow  out  1  sticky; response received with tag FIFO empty.

## Operation
- FSM has two states.
  - IDLE: arbitration.
  - BURST: locked to owner.
- **Round-robin:** winner = requester ≠ last_grant if it requests, else the other requester.
- **IDLE:**
  - If the tag FIFO is not full and any s_write is high, mux the winner onto m_*. Winner s_waitrequest = m_waitrequest; loser s_waitrequest = 1.
  - If the tag FIFO is full: m_write = 0 and s_waitrequest = 2'b11.
- **First-beat accept** (m_write & !m_waitrequest in IDLE):
  - Push {owner, burstcount} into the tag FIFO.
  - If burstcount = 1: stay IDLE, last_grant ← owner.
  - Otherwise: go to BURST, owner latched, beats_left ← burstcount−1.
- **BURST:**
  - m_* is muxed from the owner only. Owner s_waitrequest = m_waitrequest; other requester = 1.
  - m_burstcount is passed through from the owner on every beat.
  - Each accepted beat decrements beats_left. On the beat where beats_left = 1: go to IDLE, last_grant ← owner.
- **Response:** on m_writeresponsevalid, pop the FIFO head {id, bc}; ack_cnt[id] += bc.
- **Ack counters:**
  - s_writeack[i] = |ack_cnt[i] (combinational from the register).
  - ack_cnt[i] decrements by 1 each cycle it is non-zero.
  - Simultaneous add and decrement on the same counter: ack_cnt ← ack_cnt + bc − 1.
- **Widths:** ack_cnt is AVMM_BURSTCNT_WIDTH + log2(TAG_FIFO_DEPTH) bits and never wraps. The FIFO count is log2(TAG_FIFO_DEPTH)+1 bits.
- **Same-cycle push and pop:** occupancy unchanged; allowed when the FIFO is full.
- **Response while FIFO empty:** ignored; no counter change; resp_underflow ← 1 until reset.

## Timing
- **Reset values:**
  - FSM = IDLE, last_grant = 1 (requester 0 wins first), FIFO empty.
  - ack_cnt = 0, s_writeack = 0, resp_underflow = 0.
  - While reset is high: m_write = 0, s_waitrequest = 2'b11.
- **Reset mid-burst:** the burst is abandoned, and outstanding tags and acks are discarded. The downstream port must be reset in the same cycle.
- **Arbitration latency:** the first beat reaches m_* in the same cycle s_write is seen in IDLE (zero-cycle request-to-m_write path).
- **Back-to-back bursts:** a burst whose last beat is accepted in cycle N allows the next grant's first beat in cycle N+1.
- **Ack latency:** m_writeresponsevalid in cycle N produces the first s_writeack in N+1. Ack bursts are contiguous at one per cycle while the counter is non-zero.
- **Ordering:** responses are credited strictly in burst-issue order via the FIFO. Acks to different requesters may overlap in the same cycle.

## Test plan
- **Single requester:** req0 burst 4, no stall → 4 beats, one FIFO push, response → s_writeack[0] high for 4 cycles starting 1 cycle after the response.
- **Alternation:** both requesters continuously issuing burst-2 → grants alternate 0,1,0,1, never interleave within a burst, and the loser sees waitrequest=1 throughout the owner's burst.
- **Back-pressure:** m_waitrequest toggled mid-burst → beat count and data order preserved, lock held until the 8th accepted beat of a burst-8.
- **FIFO full:** TAG_FIFO_DEPTH=4, issue 4 bursts with no responses → 5th request is stalled with m_write=0. A response arriving in the same cycle as the 5th request's first beat accepts it after the pop.
- **Overlapping acks:** req0 burst 3 response, then the req0 burst 5 response 1 cycle later → ack_cnt path 3→7→6…, giving 8 consecutive s_writeack[0] cycles. A req1 response arriving meanwhile raises s_writeack[1] concurrently.
- **Underflow and reset:** response with FIFO empty → resp_underflow=1, no acks. Reset mid-burst → all outputs at reset values on the next cycle, and req1 can then win fresh arbitration.
